// File: rtl/sweep_acq_data_sink_pkg.sv
// Shared constants and FSM state type for the sweep-acquisition data sink.
// SWEEP_HEADER/SWEEP_TAIL are the controller framing words, used by benches.
package sweep_acq_data_sink_pkg;
  localparam logic [15:0] SWEEP_HEADER    = 16'h5341;
  localparam logic [15:0] SWEEP_TAIL      = 16'hFF45;
  localparam int          DEF_DEPTH       = 16;
  localparam int          DEF_AFULL_LEVEL = 12;

  typedef enum logic [2:0] {IDLE, STREAM, FLUSH, TRAILER, DONE} state_t;
endpackage

// File: rtl/sweep_acq_data_sink_fifo.sv
// Single-clock DEPTH x 16 FIFO with registered read data, occupancy and flags.
module sweep_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          reset_n,
  input  logic          i_wr_en,
  input  logic [15:0]   i_wr_data,
  input  logic          i_rd_en,
  output logic [15:0]   o_rd_data,
  output logic [AW:0]   o_count,
  output logic          o_empty,
  output logic          o_full
);
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  logic [15:0]   r_rd_data;
  logic          w_rd, w_wr;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_rd_data = r_rd_data;
  assign w_rd      = i_rd_en && !o_empty;
  // a full buffer still takes a word when a read frees a slot this cycle
  assign w_wr      = i_wr_en && (!o_full || w_rd);

  always_ff @(posedge Clk) begin
    if (w_wr) r_mem[r_wp] <= i_wr_data;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) begin
        r_rp      <= r_rp + 1'b1;
        r_rd_data <= r_mem[r_rp];
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/sweep_acq_data_sink.sv
// Sweep-acquisition data sink: buffers controller words, drains to USB FIFO,
// raises DataTransmitDone after flush. SWEEP_WORD_COUNT_EN appends a word-count trailer.
module sweep_acq_data_sink
  import sweep_acq_data_sink_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int AFULL_LEVEL = DEF_AFULL_LEVEL
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic [15:0] SweepACQData,
  input  logic        SweepACQData_en,
  input  logic        ACQDone,
  output logic        DataTransmitDone,
  output logic        BufferAlmostFull,
  input  logic        UsbFifoFull,
  output logic [15:0] UsbFifoData,
  output logic        UsbFifoWrEn,
  output logic [15:0] WordCount,
  output logic        Overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_AFULL = (AW+1)'(AFULL_LEVEL);

  state_t      r_state, w_state_nxt;
  logic        r_acq_d, r_rd_vld, r_dtd, r_afull, r_ovf;
  logic [15:0] r_wc;
  logic [15:0] w_rd_data, w_wc_nxt;
  logic [AW:0] w_count;
  logic        w_empty, w_full, w_rd, w_drop, w_start, w_acq_rise, w_flushed;

  sweep_sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .Clk       (Clk),
    .reset_n   (reset_n),
    .i_wr_en   (SweepACQData_en),
    .i_wr_data (SweepACQData),
    .i_rd_en   (w_rd),
    .o_rd_data (w_rd_data),
    .o_count   (w_count),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

`ifdef SWEEP_WORD_COUNT_EN
  logic        r_trl_wr;
  logic [15:0] r_wc_snap;
  // the trailer owns the USB port while in TRAILER, so the buffer is not drained
  assign w_rd        = !w_empty && !UsbFifoFull && (r_state != TRAILER);
  assign UsbFifoWrEn = r_rd_vld | r_trl_wr;
  assign UsbFifoData = r_trl_wr ? r_wc_snap : w_rd_data;
`else
  assign w_rd        = !w_empty && !UsbFifoFull;
  assign UsbFifoWrEn = r_rd_vld;
  assign UsbFifoData = w_rd_data;
`endif

  assign w_drop     = SweepACQData_en && w_full && !w_rd;
  assign w_start    = (r_state == IDLE) && SweepACQData_en;
  assign w_wc_nxt   = w_start ? 16'd1 : r_wc + 16'd1;
  assign w_acq_rise = ACQDone && !r_acq_d;
  // nothing buffered, nothing on the USB port, nothing arriving
  assign w_flushed  = w_empty && !r_rd_vld && !SweepACQData_en;

  assign DataTransmitDone = r_dtd;
  assign BufferAlmostFull = r_afull;
  assign WordCount        = r_wc;
  assign Overflow         = r_ovf;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (SweepACQData_en) w_state_nxt = STREAM;
      STREAM: if (w_acq_rise)      w_state_nxt = FLUSH;
`ifdef SWEEP_WORD_COUNT_EN
      FLUSH:   if (w_flushed) w_state_nxt = TRAILER;
      TRAILER: if (r_trl_wr)  w_state_nxt = DONE;
`else
      FLUSH:   if (w_flushed) w_state_nxt = DONE;
`endif
      DONE: begin
        if (SweepACQData_en || !w_empty) w_state_nxt = FLUSH;
        else if (!ACQDone)               w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_acq_d  <= 1'b0;
      r_rd_vld <= 1'b0;
      r_dtd    <= 1'b0;
      r_afull  <= 1'b0;
      r_ovf    <= 1'b0;
      r_wc     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_acq_d  <= ACQDone;
      r_rd_vld <= w_rd;
      r_dtd    <= (w_state_nxt == DONE) && ACQDone;
      r_afull  <= (w_count >= L_AFULL);
      if (SweepACQData_en) begin
        r_wc  <= w_wc_nxt;
        r_ovf <= w_start ? w_drop : (r_ovf | w_drop);
      end
    end
  end

`ifdef SWEEP_WORD_COUNT_EN
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_trl_wr  <= 1'b0;
      r_wc_snap <= '0;
    end else begin
      r_trl_wr <= (r_state == TRAILER) && !r_trl_wr && !UsbFifoFull;
      if (r_state == STREAM && w_acq_rise)
        r_wc_snap <= SweepACQData_en ? w_wc_nxt : r_wc;
    end
  end
`endif
endmodule

// File: tb/tb_sweep_acq_data_sink.sv
// Directed bench for sweep_acq_data_sink; expectations adapt to SWEEP_WORD_COUNT_EN.
module tb_sweep_acq_data_sink;
  import sweep_acq_data_sink_pkg::*;

`ifdef SWEEP_WORD_COUNT_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  logic        Clk, reset_n;
  logic [15:0] SweepACQData;
  logic        SweepACQData_en, ACQDone, UsbFifoFull;
  logic        DataTransmitDone, BufferAlmostFull, UsbFifoWrEn, Overflow;
  logic [15:0] UsbFifoData, WordCount;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] q[$];
  logic [15:0] ex[$];

  sweep_acq_data_sink dut (
    .Clk              (Clk),
    .reset_n          (reset_n),
    .SweepACQData     (SweepACQData),
    .SweepACQData_en  (SweepACQData_en),
    .ACQDone          (ACQDone),
    .DataTransmitDone (DataTransmitDone),
    .BufferAlmostFull (BufferAlmostFull),
    .UsbFifoFull      (UsbFifoFull),
    .UsbFifoData      (UsbFifoData),
    .UsbFifoWrEn      (UsbFifoWrEn),
    .WordCount        (WordCount),
    .Overflow         (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) if (reset_n && UsbFifoWrEn) q.push_back(UsbFifoData);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic strobe(input logic [15:0] d);
    SweepACQData = d; SweepACQData_en = 1'b1;
    tick();
    SweepACQData_en = 1'b0;
  endtask

  function automatic logic [31:0] qat(input int i);
    return (i < q.size()) ? {16'h0, q[i]} : 32'hDEAD_BEEF;
  endfunction

  task automatic wait_dtd(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (DataTransmitDone) break;
      tick();
    end
    chk(tag, DataTransmitDone, 1);
  endtask

  task automatic close_session(input string tag);
    ACQDone = 1'b1; tick();
    wait_dtd(tag);
    ACQDone = 1'b0; tick();
    chk({tag, "_fall"}, DataTransmitDone, 0);
  endtask

  initial begin
    reset_n = 1'b0; SweepACQData = '0; SweepACQData_en = 1'b0;
    ACQDone = 1'b0; UsbFifoFull = 1'b0;
    #12;
    chk("rst_wren", UsbFifoWrEn, 0);
    chk("rst_data", UsbFifoData, 0);
    chk("rst_wc", WordCount, 0);
    chk("rst_dtd", DataTransmitDone, 0);
    chk("rst_baf", BufferAlmostFull, 0);
    chk("rst_ovf", Overflow, 0);
    tick(); reset_n = 1'b1; tick();

    // full session at line rate, including pass-through latency
    ex.delete(); q.delete();
    ex.push_back(SWEEP_HEADER); ex.push_back(16'hD000);
    for (int i = 1; i <= 10; i++) ex.push_back(16'h1000 + 16'(i));
    ex.push_back(SWEEP_TAIL);
    strobe(ex[0]);
    chk("t1_lat0_wren", UsbFifoWrEn, 0);
    tick();
    chk("t1_lat2_wren", UsbFifoWrEn, 1);
    chk("t1_lat2_data", UsbFifoData, SWEEP_HEADER);
    for (int i = 1; i < 13; i++) strobe(ex[i]);
    chk("t1_wc", WordCount, 13);
    ACQDone = 1'b1; tick();
    wait_dtd("t1_dtd");
    chk("t1_wren_at_dtd", UsbFifoWrEn, 0);
    chk("t1_nwr", q.size(), 13 + TRL);
    for (int i = 0; i < 13; i++) chk($sformatf("t1_w%0d", i), qat(i), {16'h0, ex[i]});
`ifdef SWEEP_WORD_COUNT_EN
    chk("t1_trailer", qat(13), 32'h000D);
`endif
    chk("t1_ovf", Overflow, 0);
    ACQDone = 1'b0; tick();
    chk("t1_dtd_fall", DataTransmitDone, 0);

    // back-pressure threshold with USB FIFO full
    q.delete(); UsbFifoFull = 1'b1;
    for (int i = 0; i < 11; i++) strobe(16'h2000 + 16'(i));
    chk("t2_wc_restart", WordCount, 11);
    tick();
    chk("t2_baf11", BufferAlmostFull, 0);
    strobe(16'h200B); tick();
    chk("t2_baf12", BufferAlmostFull, 1);
    chk("t2_held", q.size(), 0);
    UsbFifoFull = 1'b0;
    repeat (20) tick();
    chk("t2_nwr", q.size(), 12);
    for (int i = 0; i < 12; i += 11) chk($sformatf("t2_w%0d", i), qat(i), 32'h2000 + i);
    chk("t2_baf_clr", BufferAlmostFull, 0);
    chk("t2_ovf", Overflow, 0);
    close_session("t2_dtd");

    // overflow: 18 words into a 16-deep buffer
    q.delete(); UsbFifoFull = 1'b1;
    for (int i = 0; i < 18; i++) strobe(16'h3000 + 16'(i));
    tick();
    chk("t3_ovf", Overflow, 1);
    chk("t3_wc", WordCount, 18);
    UsbFifoFull = 1'b0;
    repeat (30) tick();
    chk("t3_nwr", q.size(), 16);
    chk("t3_first", qat(0), 32'h3000);
    chk("t3_last", qat(15), 32'h300F);
    close_session("t3_dtd");

    // ACQDone with words still buffered behind a full USB FIFO
    q.delete(); UsbFifoFull = 1'b1;
    for (int i = 0; i < 5; i++) strobe(16'h4000 + 16'(i));
    chk("t4_ovf_cleared", Overflow, 0);
    ACQDone = 1'b1;
    repeat (10) tick();
    chk("t4_dtd_held", DataTransmitDone, 0);
    chk("t4_held", q.size(), 0);
    UsbFifoFull = 1'b0;
    wait_dtd("t4_dtd");
    chk("t4_nwr", q.size(), 5 + TRL);
`ifdef SWEEP_WORD_COUNT_EN
    chk("t4_trailer", qat(5), 32'h0005);
`endif
    ACQDone = 1'b0; tick();
    chk("t4_dtd_fall", DataTransmitDone, 0);

    // reset mid-stream with 6 words buffered
    q.delete(); UsbFifoFull = 1'b1;
    for (int i = 0; i < 6; i++) strobe(16'h5000 + 16'(i));
    tick();
    reset_n = 1'b0; UsbFifoFull = 1'b0; #2;
    chk("t6_wren", UsbFifoWrEn, 0);
    chk("t6_data", UsbFifoData, 0);
    chk("t6_wc", WordCount, 0);
    chk("t6_baf", BufferAlmostFull, 0);
    chk("t6_ovf", Overflow, 0);
    tick(); tick(); reset_n = 1'b1;
    repeat (10) tick();
    chk("t6_nowr", q.size(), 0);
    strobe(16'h6000);
    chk("t6_wc1", WordCount, 1);
    tick(); tick();
    chk("t6_nwr", q.size(), 1);
    chk("t6_w0", qat(0), 32'h6000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sweep_acq_data_sink.md
# sweep_acq_data_sink

Downstream stage of the sweep-acquisition controller. Accepts the controller's 16-bit word stream (header, DAC tags, hit data, tail) and buffers it in a 16-deep FIFO. Drains the buffer into the USB data FIFO under that FIFO's full flag, and gives the controller early back-pressure. Generates the `DataTransmitDone` handshake that releases the controller from its final state once every word of the sweep has reached the USB FIFO.

## Interface
Parameters:
- `DEPTH`, 16: buffer depth in words (power of two).
- `AFULL_LEVEL`, 12: occupancy at or above which `BufferAlmostFull` asserts.

Ports:
- `Clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset. Single clock domain.
- `SweepACQData` in 16: word from the controller.
- `SweepACQData_en` in 1: one-cycle write strobe for `SweepACQData`.
- `ACQDone` in 1: controller level, high after the tail word has been strobed.
- `DataTransmitDone` out 1: level, high while the flush is complete and `ACQDone` is still high.
- `BufferAlmostFull` out 1: back-pressure to the controller's `UsbDataFifoFull`.
- `UsbFifoFull` in 1: full flag of the USB data FIFO.
- `UsbFifoData` out 16: write data to the USB FIFO.
- `UsbFifoWrEn` out 1: write enable to the USB FIFO.
- `WordCount` out 16: words accepted in the current session.
- `Overflow` out 1: sticky, set when a word was dropped.

## Operation
- Reset values:
  - All outputs 0.
  - Buffer empty, state `IDLE`.
- `IDLE`:
  - The first `SweepACQData_en` starts a session and moves the FSM to `STREAM`.
  - Session start clears `WordCount` and `Overflow`.
  - The first word itself is accepted and counted.
- `STREAM`:
  - Each strobe writes one word and increments `WordCount`.
  - `WordCount` wraps at 0xFFFF → 0x0000.
  - Rising `ACQDone` moves the FSM to `FLUSH`.
- `FLUSH`:
  - Continue draining the buffer.
  - When the buffer is empty and no write is in flight, go to `TRAILER` (macro on) or `DONE` (macro off).
- `DONE`:
  - `DataTransmitDone` = 1 while `ACQDone` = 1.
  - When `ACQDone` falls, `DataTransmitDone` goes to 0 on the next edge and the FSM returns to `IDLE`.
- Drain rule: one word per cycle whenever the buffer is not empty and `UsbFifoFull` = 0. `UsbFifoFull` is sampled in the same cycle the read is issued.
- Back-pressure: `BufferAlmostFull` = (occupancy ≥ `AFULL_LEVEL`), registered. The controller can emit up to 3 further words after sampling it, so the slack is 4.
- Full buffer:
  - With no simultaneous read, the strobed word is dropped, `Overflow` is set and `WordCount` still increments.
  - With a read in the same cycle, the word is accepted.
- A strobe while in `FLUSH`/`DONE` (protocol error) is still buffered and counted. The flush exit condition is then re-evaluated.
- Reset mid-session empties the buffer without emitting a trailer.

## Timing
- Pass-through latency: strobe at edge N into an empty buffer with `UsbFifoFull` = 0 gives `UsbFifoWrEn` = 1 with that word during cycle N+1 to N+2. The read is registered; total latency is 2 cycles.
- `UsbFifoWrEn` is a one-cycle pulse per word. Back-to-back words give a continuous high level.
- `UsbFifoFull` rising stops reads the following cycle. A word already presented is still written.
- `BufferAlmostFull` updates 1 cycle after the occupancy change.
- `DataTransmitDone` rises ≥ 1 cycle after the last `UsbFifoWrEn`.

## Configuration
- `SWEEP_WORD_COUNT_EN` defined:
  - `FLUSH` is followed by `TRAILER`.
  - `TRAILER` writes one extra word `WordCount` (value at `ACQDone` rise) once `UsbFifoFull` = 0, then goes to `DONE`.
- Undefined: no `TRAILER` state, and the USB stream is exactly the controller's words.
- `WordCount` and `Overflow` ports exist in both builds.

## Structure
- Shared package holds:
  - `SWEEP_HEADER` = 16'h5341 and `SWEEP_TAIL` = 16'hFF45, used by benches only.
  - The default `DEPTH`/`AFULL_LEVEL` values.
  - The FSM state enum: `IDLE`, `STREAM`, `FLUSH`, `TRAILER`, `DONE`.
- One sub-module, `sweep_sync_fifo`:
  - Single-clock, `DEPTH`×16, registered read data.
  - Exposes occupancy count plus empty/full flags.
- FSM, counters and flags live in the top.

## Test plan
- Stream 0x5341, 0xD000, ten data words, 0xFF45, then `ACQDone` = 1, with `UsbFifoFull` = 0 → 13 writes in order, `WordCount` = 13, `DataTransmitDone` = 1 after the last write. `ACQDone` = 0 → `DataTransmitDone` = 0 next cycle, FSM back in `IDLE`.
- Hold `UsbFifoFull` = 1 and strobe 12 words → `BufferAlmostFull` = 1 after the 12th. Release → 12 writes, no loss, `BufferAlmostFull` clears.
- Hold `UsbFifoFull` = 1 and strobe 18 words → `Overflow` = 1, `WordCount` = 18, exactly 16 words later written.
- `ACQDone` rises with 5 words buffered and `UsbFifoFull` = 1 → `DataTransmitDone` stays 0 until all 5 are written.
- With `SWEEP_WORD_COUNT_EN`, a 13-word session → 14th write = 0x000D, then `DataTransmitDone`.
- Assert `reset_n` = 0 mid-stream with 6 words buffered → no further writes, all outputs 0. A new session restarts with `WordCount` = 1.
